// File: rtl/pc_update_ras.sv
// PC-update stage: architectural PC register with stall, sticky halt, and a
// circular return-address stack that checks ret targets against its prediction.
module pc_update_ras #(
    parameter int                 WIDTH    = 64,
    parameter int                 DEPTH    = 8,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic [3:0]                 icode,
    input  logic                       cnd,
    input  logic [WIDTH-1:0]           valC,
    input  logic [WIDTH-1:0]           valM,
    input  logic [WIDTH-1:0]           valP,
    output logic [WIDTH-1:0]           pc,
    output logic                       halted,
    output logic [WIDTH-1:0]           ras_top,
    output logic [$clog2(DEPTH):0]     ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ret_mispredict,
    output logic                       ras_underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_m1;
    logic             upd;
    logic             push;
    logic             pop;

    assign upd       = in_valid & ~stall & ~halted;
    assign push      = upd && (icode == IC_CALL);
    assign pop       = upd && (icode == IC_RET) && !ras_empty;
    assign ptr_m1    = ptr - 1'b1;
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(DEPTH));
    assign ras_top   = ras_empty ? '0 : mem[ptr_m1];

    // Stack storage carries no reset; validity is tracked by ras_count alone.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[ptr] <= valP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            halted         <= 1'b0;
            ptr            <= '0;
            ras_count      <= '0;
            ret_mispredict <= 1'b0;
            ras_underflow  <= 1'b0;
        end else begin
            ret_mispredict <= 1'b0;
            ras_underflow  <= 1'b0;
            if (upd) begin
                case (icode)
                    IC_HALT: halted <= 1'b1;
                    IC_JXX:  pc     <= cnd ? valC : valP;
                    IC_CALL: pc     <= valC;
                    IC_RET:  pc     <= valM;
                    default: pc     <= valP;
                endcase
            end
            if (push) begin
                ptr <= ptr + 1'b1;
                if (!ras_full) begin
                    ras_count <= ras_count + 1'b1;
                end
            end
            if (pop) begin
                ret_mispredict <= (mem[ptr_m1] != valM);
                ptr            <= ptr_m1;
                ras_count      <= ras_count - 1'b1;
            end
            if (upd && (icode == IC_RET) && ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end
endmodule
